traffic_phase_timer: RTL and testbench

TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

---
 rtl/traffic_phase_timer.sv | 160 ++++++++++++++++
 tb/tb_traffic_phase_timer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
//
// Sets how long each traffic-light phase lasts and emits a one-cycle
// `advance` pulse that steps the downstream light FSM (RED -> GREEN ->
// YELLOW -> RED). The block also latches pedestrian requests. A latched
// request can shorten the current GREEN phase. It is served by turning on
// the walk lamp for the whole of the next RED phase.
//
// Handshake: none. `advance` is a plain one-cycle strobe with no back-pressure.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous, active-low reset
//   enable       in   1 = timing runs, 0 = countdown and phase frozen
//   tick_en      in   one-clk prescaler pulse; each pulse is one tick
//   ped_req      in   asynchronous pedestrian button (level)
//   phase        out  current phase: 00 RED, 01 GREEN, 10 YELLOW
//                     (this is the FSM state register, exposed directly)
//   advance      out  one-clk pulse on every phase transition
//   remaining    out  ticks left in the current phase, minus 1
//   ped_pending  out  a pedestrian request is latched but not yet served
//   walk         out  walk lamp; high for a RED phase that serves a request
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module traffic_phase_timer #(
    parameter int CNT_W        = 16,
    parameter int RED_TICKS    = 20,
    parameter int GREEN_TICKS  = 30,
    parameter int YELLOW_TICKS = 5,
    parameter int GREEN_MIN    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             tick_en,
    input  logic             ped_req,
    output logic [1:0]       phase,
    output logic             advance,
    output logic [CNT_W-1:0] remaining,
    output logic             ped_pending,
    output logic             walk
);

    typedef enum logic [1:0] {
        PH_RED    = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10
    } phase_e;

    // Each counter load is the phase length minus one, because the
    // transition happens on the tick that sees remaining == 0.
    localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] TRUNC_LOAD  = CNT_W'(GREEN_MIN - 1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             adv_q, adv_d;
    logic             ped_q, ped_d;
    logic             walk_q, walk_d;

    // The first two flops synchronise the button. The third holds the
    // previous synchronised level so that a rising edge can be detected.
    logic sync1_q, sync2_q, sync3_q;
    logic ped_edge;
    logic qual_tick;

    assign ped_edge  = sync2_q & ~sync3_q;
    assign qual_tick = enable & tick_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= ped_req;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_RED;
            rem_q   <= RED_LOAD;
            adv_q   <= 1'b0;
            ped_q   <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            rem_q   <= rem_d;
            adv_q   <= adv_d;
            ped_q   <= ped_d;
            walk_q  <= walk_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        rem_d   = rem_q;
        adv_d   = 1'b0;
        ped_d   = ped_q;
        walk_d  = walk_q;

        // A button edge is latched whether or not timing is enabled.
        // Further edges while a request is already pending change nothing.
        if (ped_edge) begin
            ped_d = 1'b1;
        end

        if (qual_tick) begin
            if (rem_q == '0) begin
                adv_d = 1'b1;
                case (phase_q)
                    PH_RED: begin
                        phase_d = PH_GREEN;
                        rem_d   = GREEN_LOAD;
                        walk_d  = 1'b0;
                    end
                    PH_GREEN: begin
                        phase_d = PH_YELLOW;
                        rem_d   = YELLOW_LOAD;
                    end
                    PH_YELLOW: begin
                        phase_d = PH_RED;
                        rem_d   = RED_LOAD;
                        // An edge arriving in this same cycle is served now
                        // and is not left pending. This assignment
                        // overrides the edge latch above.
                        if (ped_q || ped_edge) begin
                            walk_d = 1'b1;
                            ped_d  = 1'b0;
                        end
                    end
                    default: begin
                        phase_d = PH_RED;
                        rem_d   = RED_LOAD;
                    end
                endcase
            end else if ((phase_q == PH_GREEN) && ped_q && (rem_q > TRUNC_LOAD)) begin
                // Cut GREEN short. After this load remaining is at or below
                // TRUNC_LOAD, so truncation cannot fire again in this phase.
                rem_d = TRUNC_LOAD;
            end else begin
                rem_d = rem_q - CNT_W'(1);
            end
        end
    end

    assign phase       = phase_q;
    assign advance     = adv_q;
    assign remaining   = rem_q;
    assign ped_pending = ped_q;
    assign walk        = walk_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_timer
//
// Directed bench for traffic_phase_timer with RED=4, GREEN=8, YELLOW=2 and
// GREEN_MIN=2.
//
// The bench keeps its own count of qualifying ticks, `t`. The expected phase,
// remaining and advance are derived from t modulo the 14-tick cycle.
// Expected walk and ped_pending values are given with each directed step.
// A pedestrian truncation is modelled as a jump in t to the truncated point.
// Observed outputs are packed as {walk, ped_pending, advance, phase, remaining}.
// -----------------------------------------------------------------------------
module tb_traffic_phase_timer;

    localparam int CNT_W = 16;
    localparam int W     = CNT_W + 5;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             tick_en;
    logic             ped_req;
    logic [1:0]       phase;
    logic             advance;
    logic [CNT_W-1:0] remaining;
    logic             ped_pending;
    logic             walk;

    logic [W-1:0] exp_q[$];
    int           t;
    int           t_skip;
    int           n_total;
    int           n_pass;

    traffic_phase_timer #(
        .CNT_W       (CNT_W),
        .RED_TICKS   (4),
        .GREEN_TICKS (8),
        .YELLOW_TICKS(2),
        .GREEN_MIN   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .tick_en    (tick_en),
        .ped_req    (ped_req),
        .phase      (phase),
        .advance    (advance),
        .remaining  (remaining),
        .ped_pending(ped_pending),
        .walk       (walk)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- expected-value model ----------------
    function automatic logic [W-1:0] exp_at(input int tc, input logic qual,
                                            input logic w, input logic p);
        int               tt;
        logic [1:0]       ph;
        logic [CNT_W-1:0] rem;
        logic             adv;
        tt = tc % 14;
        if (tt < 4) begin
            ph  = 2'b00;
            rem = CNT_W'(3 - tt);
        end else if (tt < 12) begin
            ph  = 2'b01;
            rem = CNT_W'(11 - tt);
        end else begin
            ph  = 2'b10;
            rem = CNT_W'(13 - tt);
        end
        adv = qual && ((tt == 0) || (tt == 4) || (tt == 12));
        return {w, p, adv, ph, rem};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_obs(input string tag);
        logic [W-1:0] obs;
        logic [W-1:0] expv;
        obs  = {walk, ped_pending, advance, phase, remaining};
        expv = exp_q.pop_front();
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, expv, t);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change only at the falling edge. Their values are captured here
    // before the rising edge, and outputs are sampled at the next falling edge.
    task automatic step(input string tag, input logic w, input logic p);
        logic qual;
        qual = enable & tick_en;
        @(posedge clk);
        if (qual) begin
            t      = t + 1 + t_skip;
            t_skip = 0;
        end
        exp_q.push_back(exp_at(t, qual, w, p));
        @(negedge clk);
        check_obs(tag);
    endtask

    task automatic steps(input int n, input string tag, input logic w, input logic p);
        for (int i = 0; i < n; i++) step(tag, w, p);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        tick_en = 1'b1;
        ped_req = 1'b0;
        t       = 0;
        t_skip  = 0;
        n_total = 0;
        n_pass  = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        exp_q.push_back({1'b0, 1'b0, 1'b0, 2'b00, CNT_W'(3)});
        check_obs("reset_state");
        rst_n = 1'b1;

        // Free run for two full cycles. Advance is expected after 4, 12, 14
        // and 18 ticks, and after 26 and 28.
        steps(28, "free_run", 1'b0, 1'b0);

        // Enable pause mid-GREEN at remaining 5, then resume at 4.
        steps(6, "to_green5", 1'b0, 1'b0);
        enable = 1'b0;
        steps(5, "pause_hold", 1'b0, 1'b0);
        enable = 1'b1;
        step("resume", 1'b0, 1'b0);
        steps(9, "to_red1", 1'b0, 1'b0);

        // ped_pending appears 3 edges after ped_req rises, here with GREEN
        // remaining 6. The next tick truncates to 1.
        ped_req = 1'b1;
        step("ped_lat1", 1'b0, 1'b0);
        step("ped_lat2", 1'b0, 1'b0);
        ped_req = 1'b0;
        step("ped_set", 1'b0, 1'b1);
        t_skip = 4;
        step("trunc", 1'b0, 1'b1);
        steps(3, "green_yellow", 1'b0, 1'b1);
        steps(4, "walk_red", 1'b1, 1'b0);
        step("walk_off", 1'b0, 1'b0);

        // Request latched at GREEN remaining 1: no truncation.
        steps(3, "to_green8", 1'b0, 1'b0);
        ped_req = 1'b1;
        steps(2, "ped_lat_b", 1'b0, 1'b0);
        ped_req = 1'b0;
        step("ped_set_r1", 1'b0, 1'b1);
        steps(3, "no_trunc", 1'b0, 1'b1);
        step("walk_red_b", 1'b1, 1'b0);

        // Edge while walk is on: it stays pending, and walk is not extended.
        ped_req = 1'b1;
        steps(2, "walk_edge", 1'b1, 1'b0);
        ped_req = 1'b0;
        step("walk_pend", 1'b1, 1'b1);
        step("walk_not_ext", 1'b0, 1'b1);
        t_skip = 5;
        step("trunc_full", 1'b0, 1'b1);
        steps(3, "green_yellow_c", 1'b0, 1'b1);
        steps(4, "walk_red_c", 1'b1, 1'b0);
        step("walk_off_c", 1'b0, 1'b0);

        // Edge detected in the YELLOW->RED cycle itself: served immediately.
        steps(7, "to_green0", 1'b0, 1'b0);
        ped_req = 1'b1;
        steps(2, "yellow_edge", 1'b0, 1'b0);
        ped_req = 1'b0;
        steps(4, "same_cycle_walk", 1'b1, 1'b0);
        steps(2, "green_clean", 1'b0, 1'b0);

        // tick_en high 1 cycle in 4.
        for (int i = 0; i < 60; i++) begin
            tick_en = (i % 4 == 0);
            step("tick_div", 1'b0, 1'b0);
        end
        tick_en = 1'b1;

        // Asynchronous reset mid-YELLOW while a request is pending.
        step("to_green3", 1'b0, 1'b0);
        ped_req = 1'b1;
        steps(2, "ped_lat_d", 1'b0, 1'b0);
        ped_req = 1'b0;
        steps(3, "pend_yellow", 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 2'b00, CNT_W'(3)});
        check_obs("async_rst");
        @(negedge clk);
        exp_q.push_back({1'b0, 1'b0, 1'b0, 2'b00, CNT_W'(3)});
        check_obs("rst_hold");
        rst_n  = 1'b1;
        t      = 0;
        t_skip = 0;
        steps(3, "post_rst", 1'b0, 1'b0);
        step("first_adv", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
